// File: rtl/fetch_unit.sv
// fetch_unit: program counter and instruction register feeding a 13-bit instruction ROM
module fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 13,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  input  logic               jmp_valid,
  input  logic [ADDR_W-1:0]  jmp_addr,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               rom_en,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, ipc_q, ipc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               slot_free;
  assign slot_free   = !valid_q || instr_ready;
  assign rom_en      = (state_q == RUN) && slot_free && !jmp_valid && !halt;
  assign rom_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign busy        = state_q == RUN;
  // next state: a jump flushes the slot and wins over fetch and accept; pc wraps silently
  always_comb begin
    state_d = state_q == IDLE ? (start ? RUN : IDLE) : (halt ? IDLE : RUN);
    pc_d    = jmp_valid ? jmp_addr : rom_en ? pc_q + ADDR_W'(1) : pc_q;
    instr_d = rom_en ? rom_data : instr_q;
    ipc_d   = rom_en ? pc_q : ipc_q;
    valid_d = jmp_valid ? 1'b0 : rom_en ? 1'b1 : instr_ready ? 1'b0 : valid_q;
  end
  // state registers with synchronous reset that discards any held word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RST_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end
endmodule
